// File: rtl/mc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mc_cpu_pkg
// Description : Shared definitions for the 8-bit multi-cycle teaching CPU:
//               opcode constants, one-hot control-FSM state encoding, the
//               control vector layout and the performance-counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mc_cpu_pkg;

    // Opcode field Instr_Op
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // Default performance-counter width
    localparam int CNT_W_DEF = 8;

    // One-hot state encoding; bit order matches the State_* outputs
    typedef enum logic [4:0] {
        ST_FETCH  = 5'b00001,
        ST_DECODE = 5'b00010,
        ST_EXEC   = 5'b00100,
        ST_MEM    = 5'b01000,
        ST_WB     = 5'b10000
    } state_t;

    // Datapath/memory control vector
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
        logic alu_src;
        logic pc_write;
        logic jump;
    } ctrl_t;

endpackage : mc_cpu_pkg
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : mc_ctrl_decode
// Description : Combinational map from (next state, opcode) to the control
//               vector. The result is registered by mc_control_fsm, so the
//               controls become valid on the same edge the state is entered.
// Ports       : i_state - state being entered on this edge
//               i_op    - opcode that will be held in Op_q after this edge
//               o_ctrl  - decoded control vector
// Revision    : 1.0 - initial release
// ============================================================================
module mc_ctrl_decode
    import mc_cpu_pkg::*;
(
    input  state_t     i_state,
    input  logic [1:0] i_op,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            ST_DECODE: begin
                o_ctrl.pc_write = 1'b1;
            end
            ST_EXEC, ST_MEM: begin
                // Driven from EXEC so the memory sees stable controls a full
                // cycle before State_Memory rises.
                o_ctrl.mem_read  = (i_op == OP_LW);
                o_ctrl.mem_write = (i_op == OP_SW);
                o_ctrl.alu_src   = (i_op == OP_LW) || (i_op == OP_SW);
            end
            ST_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = (i_op == OP_LW);
            end
            ST_FETCH: begin
                // A JMP never visits MEM or WB, so entering FETCH with a JMP
                // opcode can only be the EXEC->FETCH jump transition.
                o_ctrl.pc_write = (i_op == OP_JMP);
                o_ctrl.jump     = (i_op == OP_JMP);
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule : mc_ctrl_decode
`default_nettype wire

// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mc_control_fsm
// Description : Multi-cycle control unit. Sequences Fetch, Decode, Execute,
//               Memory and WriteBack under a Step enable and drives one-hot
//               state strobes plus registered datapath/memory controls.
// Ports       : CLK, RST (async, active-high), Step, Instr_Op[1:0]
//               State_Fetch/Decode/Execute/Memory/WriteBack
//               MemRead, MemWrite, RegWrite, MemtoReg, ALUSrc, PCWrite, Jump
//               Cycle_Count, Instr_Count [CNT_W-1:0]
// Config      : CTRL_PERF_CNT_EN - builds the cycle/instruction counters;
//               when undefined both counter outputs are tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_control_fsm
    import mc_cpu_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Step,
    input  logic [1:0]       Instr_Op,
    output logic             State_Fetch,
    output logic             State_Decode,
    output logic             State_Execute,
    output logic             State_Memory,
    output logic             State_WriteBack,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             ALUSrc,
    output logic             PCWrite,
    output logic             Jump,
    output logic [CNT_W-1:0] Cycle_Count,
    output logic [CNT_W-1:0] Instr_Count
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_op;
    logic [1:0] w_op_next;
    logic       w_illegal;
    ctrl_t      r_ctrl;
    ctrl_t      w_ctrl_dec;
    ctrl_t      w_ctrl_next;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_FETCH;
            r_op    <= OP_ADD;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            r_op    <= w_op_next;
            r_ctrl  <= w_ctrl_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_op_next = r_op;
        w_illegal = 1'b0;
        case (r_state)
            ST_FETCH:  if (Step) w_next = ST_DECODE;
            ST_DECODE: if (Step) begin
                w_next    = ST_EXEC;
                w_op_next = Instr_Op;
            end
            ST_EXEC:   if (Step) begin
                case (r_op)
                    OP_LW, OP_SW: w_next = ST_MEM;
                    OP_ADD:       w_next = ST_WB;
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEM:    if (Step) w_next = (r_op == OP_LW) ? ST_WB : ST_FETCH;
            ST_WB:     if (Step) w_next = ST_FETCH;
            default: begin
                // Corrupted one-hot code: recover on the next edge
                // regardless of Step so the CPU cannot lock up.
                w_next    = ST_FETCH;
                w_illegal = 1'b1;
            end
        endcase
    end

    mc_ctrl_decode u_decode (
        .i_state (w_next),
        .i_op    (w_op_next),
        .o_ctrl  (w_ctrl_dec)
    );

    always_comb begin
        w_ctrl_next = w_ctrl_dec;
        if (w_illegal) begin
            w_ctrl_next = '0;
        end else if (!Step) begin
            // Stalled: levels hold, one-cycle pulses must not repeat.
            w_ctrl_next          = r_ctrl;
            w_ctrl_next.pc_write = 1'b0;
            w_ctrl_next.jump     = 1'b0;
        end
    end

    assign State_Fetch     = r_state[0];
    assign State_Decode    = r_state[1];
    assign State_Execute   = r_state[2];
    assign State_Memory    = r_state[3];
    assign State_WriteBack = r_state[4];

    assign MemRead  = r_ctrl.mem_read;
    assign MemWrite = r_ctrl.mem_write;
    assign RegWrite = r_ctrl.reg_write;
    assign MemtoReg = r_ctrl.mem_to_reg;
    assign ALUSrc   = r_ctrl.alu_src;
    assign PCWrite  = r_ctrl.pc_write;
    assign Jump     = r_ctrl.jump;

`ifdef CTRL_PERF_CNT_EN
    localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;
    logic             w_retire;

    // An instruction retires when FETCH is re-entered from a working state.
    assign w_retire = Step && (w_next == ST_FETCH) &&
                      ((r_state == ST_EXEC) || (r_state == ST_MEM) ||
                       (r_state == ST_WB));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else if (Step) begin
            r_cycle_cnt <= r_cycle_cnt + C_ONE;
            if (w_retire) begin
                r_instr_cnt <= r_instr_cnt + C_ONE;
            end
        end
    end

    assign Cycle_Count = r_cycle_cnt;
    assign Instr_Count = r_instr_cnt;
`else
    assign Cycle_Count = '0;
    assign Instr_Count = '0;
`endif

endmodule : mc_control_fsm
`default_nettype wire

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle control unit for the 8-bit teaching CPU. Sequences each instruction through Fetch, Decode, Execute, Memory and WriteBack, and drives the one-hot state strobes and datapath controls. It sits directly upstream of the data memory, which samples MemRead, MemWrite and Address on the rising edge of State_Memory. Advance is gated by a Step enable so the board can single-step or free-run.

## Interface
Parameters:
- CNT_W, 8: width of the performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- Step  in  1  advance enable; the FSM moves only on a CLK edge where Step=1.
- Instr_Op  in  2  opcode field of the current instruction: 00 ADD, 01 LW, 10 SW, 11 JMP.
- State_Fetch, State_Decode, State_Execute, State_Memory, State_WriteBack  out  1 each  registered one-hot state strobes.
- MemRead, MemWrite  out  1  registered data-memory controls.
- RegWrite, MemtoReg, ALUSrc, PCWrite, Jump  out  1  registered datapath controls.
- Cycle_Count  out  CNT_W  count of advancing cycles.
- Instr_Count  out  CNT_W  count of retired instructions.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, encoded one-hot. The state register drives the State_* outputs directly.
- Op_q is a 2-bit register that captures Instr_Op on the DECODE->EXEC transition. Op_q holds until the next DECODE->EXEC transition.
- State transitions (each requires Step=1):
  - FETCH -> DECODE.
  - DECODE -> EXEC.
  - EXEC -> MEM for LW or SW.
  - EXEC -> WB for ADD.
  - EXEC -> FETCH for JMP.
  - MEM -> WB for LW.
  - MEM -> FETCH for SW.
  - WB -> FETCH.
- Controls are registered and decoded from the next state and the opcode:
  - MemRead = 1 while in EXEC or MEM with Op_q = LW.
  - MemWrite = 1 while in EXEC or MEM with Op_q = SW.
  - Both memory controls are therefore stable one full cycle before State_Memory rises.
  - ALUSrc = 1 in EXEC/MEM for LW/SW; 0 otherwise.
  - RegWrite = 1 in WB.
  - MemtoReg = 1 in WB for LW.
  - PCWrite = 1 for the FETCH->DECODE transition cycle, i.e. a 1-cycle pulse while in DECODE. It is also 1 on the EXEC->FETCH transition for JMP, together with Jump = 1 for that one cycle.
- Step = 0: state, Op_q, all controls and both counters hold. Pulse-type controls (PCWrite, Jump) are forced to 0 while stalled.
- Counters:
  - Cycle_Count increments on every advancing edge.
  - Instr_Count increments on every transition into FETCH from EXEC, MEM or WB.
  - Both counters wrap modulo 2^CNT_W without saturation.

## Timing
- Reset values: State_Fetch = 1; all other State_* = 0; all controls = 0; Op_q = 00; both counters = 0.
- RST asserted mid-instruction returns to FETCH immediately, asynchronously.
  - State_Memory falls without creating a rising edge, so no memory write occurs.
  - An SW aborted during MEM is lost.
- Reset release: the first advancing edge goes to DECODE.
- Instruction latency in advancing cycles: ADD 4, LW 5, SW 4, JMP 3.
- Step sampled low on the edge that would enter MEM: MEM entry waits. State_Memory rises only on a Step=1 edge.
- Illegal one-hot state (for example after an upset): next state is FETCH with all controls 0.

## Configuration
- CTRL_PERF_CNT_EN defined: Cycle_Count and Instr_Count are implemented as specified above.
- CTRL_PERF_CNT_EN undefined: no counter registers are built; Cycle_Count and Instr_Count are tied to 0.

## Structure
- Shared package mc_cpu_pkg holds:
  - opcode constants OP_ADD, OP_LW, OP_SW, OP_JMP;
  - the state typedef and one-hot state constants;
  - the CNT_W default.
- One natural sub-module: mc_ctrl_decode, a combinational map from (next_state, Op_q) to the control vector. It is registered in the top.

## Test plan
- Reset, then RST mid-run: State_Fetch=1, all other outputs 0, counters 0. RST asserted in MEM during an SW returns to FETCH with MemWrite=0 within the same cycle.
- LW with Step held at 1: state sequence F,D,E,M,W,F over 5 edges. MemRead=1 from EXEC through MEM. MemtoReg=RegWrite=1 in WB. Instr_Count=1, Cycle_Count=5.
- SW followed by ADD: SW skips WB and MemWrite is high for EXEC and MEM. ADD visits no MEM and raises RegWrite only in WB. After both, Instr_Count=2, Cycle_Count=8.
- JMP: sequence F,D,E,F. PCWrite=Jump=1 for exactly one cycle on the EXEC->FETCH transition.
- Step toggled 1,0,0,1 during EXEC of LW: state, Op_q and MemRead hold through the stall. State_Memory rises only on the next Step=1 edge. Cycle_Count is unchanged across the stall.
- Counter wrap with CNT_W=8 and CTRL_PERF_CNT_EN defined: after 256 advancing edges Cycle_Count=0. Without the macro, both counters read 0 throughout.
